// File: rtl/mul_pkg.sv
// Shared types and widths for the multiplier scheduler.
// Stage registers for operand (S1) and result (S2) use mul_req_t.
package mul_pkg;

  localparam int MUL_WIDTH     = 16;
  localparam int MUL_RES_WIDTH = 32;
  localparam int MUL_TAG_MAX   = 8;
  localparam int MUL_IDX_W     = 3;

  // In S2 the product occupies {num_a, num_b}
  typedef struct packed {
    logic [MUL_WIDTH-1:0]   num_a;
    logic [MUL_WIDTH-1:0]   num_b;
    logic                   sgn;
    logic [MUL_TAG_MAX-1:0] tag;
    logic [MUL_IDX_W-1:0]   idx;
  } mul_req_t;

endpackage

// File: rtl/arb_rr_xxbit.sv
// Round-robin arbiter: one-hot grant starting at ptr,
// pointer moves past the winner when the grant is accepted.
module arb_rr_xxbit #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_gnt,
  output logic [2:0]   o_gnt_idx
);

  logic [2:0] ptr_q;
  logic [2:0] ptr_d;
  logic       found;

  // Upper pass covers ptr..N-1, lower pass wraps to 0..ptr-1
  always_comb begin
    found     = 1'b0;
    o_gnt_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && i_req[j] && (3'(j) >= ptr_q)) begin
        found     = 1'b1;
        o_gnt_idx = 3'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && i_req[j]) begin
        found     = 1'b1;
        o_gnt_idx = 3'(j);
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    ptr_d = ptr_q;
    if (i_en && found) begin
      for (int j = 0; j < N; j++) begin
        o_gnt[j] = (o_gnt_idx == 3'(j));
      end
      ptr_d = (o_gnt_idx == 3'(N - 1)) ? 3'd0
                                       : o_gnt_idx + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mul_wallace_16bit.sv
// 16x16 unsigned Wallace-tree multiplier, purely combinational.
// Rows reduce 16-11-8-6-4-3-2 through 3:2 compressors, then one add.
module mul_wallace_16bit
  import mul_pkg::*;
(
  input  logic [MUL_WIDTH-1:0]     i_a,
  input  logic [MUL_WIDTH-1:0]     i_b,
  output logic [MUL_RES_WIDTH-1:0] o_prod
);

  typedef logic [MUL_RES_WIDTH-1:0] row_t;

  row_t l0 [16];
  row_t l1 [11];
  row_t l2 [8];
  row_t l3 [6];
  row_t l4 [4];
  row_t l5 [3];
  row_t l6 [2];

  function automatic logic [2*MUL_RES_WIDTH-1:0] csa(
    input row_t x,
    input row_t y,
    input row_t z
  );
    row_t s;
    row_t c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_pp
    assign l0[g] = i_b[g] ? (row_t'(i_a) << g) : '0;
  end

  for (genvar g = 0; g < 5; g++) begin : g_l1
    assign {l1[2*g], l1[2*g+1]} =
      csa(l0[3*g], l0[3*g+1], l0[3*g+2]);
  end
  assign l1[10] = l0[15];

  for (genvar g = 0; g < 3; g++) begin : g_l2
    assign {l2[2*g], l2[2*g+1]} =
      csa(l1[3*g], l1[3*g+1], l1[3*g+2]);
  end
  assign l2[6] = l1[9];
  assign l2[7] = l1[10];

  for (genvar g = 0; g < 2; g++) begin : g_l3
    assign {l3[2*g], l3[2*g+1]} =
      csa(l2[3*g], l2[3*g+1], l2[3*g+2]);
  end
  assign l3[4] = l2[6];
  assign l3[5] = l2[7];

  for (genvar g = 0; g < 2; g++) begin : g_l4
    assign {l4[2*g], l4[2*g+1]} =
      csa(l3[3*g], l3[3*g+1], l3[3*g+2]);
  end

  assign {l5[0], l5[1]} = csa(l4[0], l4[1], l4[2]);
  assign l5[2] = l4[3];

  assign {l6[0], l6[1]} = csa(l5[0], l5[1], l5[2]);

  assign o_prod = l6[0] + l6[1];

endmodule

// File: rtl/mul_16bit_sched.sv
// Round-robin front end sharing one Wallace multiplier among requesters.
// S1 holds operands, S2 holds the product and drives the response.
module mul_16bit_sched
  import mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_vld,
  output logic [NUM_REQ-1:0]           o_req_rdy,
  input  logic [NUM_REQ*MUL_WIDTH-1:0] i_req_num_a,
  input  logic [NUM_REQ*MUL_WIDTH-1:0] i_req_num_b,
  input  logic [NUM_REQ-1:0]           i_req_sgn,
  input  logic [NUM_REQ*TAG_W-1:0]     i_req_tag,
  output logic [NUM_REQ-1:0]           o_rsp_vld,
  input  logic [NUM_REQ-1:0]           i_rsp_rdy,
  output logic [MUL_RES_WIDTH-1:0]     o_rsp_res,
  output logic [TAG_W-1:0]             o_rsp_tag,
  output logic                         o_busy
);

  mul_req_t s1_q, s1_d;
  mul_req_t s2_q, s2_d;
  logic     s1_vld_q, s1_vld_d;
  logic     s2_vld_q, s2_vld_d;

  logic [NUM_REQ-1:0]       gnt;
  logic [2:0]               gnt_idx;
  logic                     acc;
  logic                     s2_xfer;
  logic                     s1_move;
  logic                     s1_open;
  logic                     neg_a, neg_b;
  logic [MUL_WIDTH-1:0]     mag_a, mag_b;
  logic [MUL_RES_WIDTH-1:0] prod_u, prod;
  logic                     unused_s2;

  assign s2_xfer = |(o_rsp_vld & i_rsp_rdy);
  assign s1_move = s1_vld_q & (~s2_vld_q | s2_xfer);
  assign s1_open = ~s1_vld_q | s1_move;

  arb_rr_xxbit #(.N(NUM_REQ)) u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req_vld),
    .i_en      (s1_open),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx)
  );

  assign o_req_rdy = gnt;
  assign acc       = |gnt;

  always_comb begin
    s1_d     = s1_q;
    s1_vld_d = s1_vld_q & ~s1_move;
    if (acc) begin
      s1_vld_d = 1'b1;
      s1_d.idx = gnt_idx;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (gnt[k]) begin
          s1_d.num_a = i_req_num_a[k*MUL_WIDTH +: MUL_WIDTH];
          s1_d.num_b = i_req_num_b[k*MUL_WIDTH +: MUL_WIDTH];
          s1_d.sgn   = i_req_sgn[k];
          s1_d.tag   = MUL_TAG_MAX'(i_req_tag[k*TAG_W +: TAG_W]);
        end
      end
    end
  end

  // 16-bit magnitude is enough: |-32768| = 0x8000
  assign neg_a = s1_q.sgn & s1_q.num_a[MUL_WIDTH-1];
  assign neg_b = s1_q.sgn & s1_q.num_b[MUL_WIDTH-1];
  assign mag_a = neg_a ? (~s1_q.num_a + 16'd1) : s1_q.num_a;
  assign mag_b = neg_b ? (~s1_q.num_b + 16'd1) : s1_q.num_b;

  mul_wallace_16bit u_core (
    .i_a    (mag_a),
    .i_b    (mag_b),
    .o_prod (prod_u)
  );

  assign prod = (neg_a ^ neg_b) ? (~prod_u + 32'd1) : prod_u;

  always_comb begin
    s2_d     = s2_q;
    s2_vld_d = s2_vld_q & ~s2_xfer;
    if (s1_move) begin
      s2_vld_d             = 1'b1;
      {s2_d.num_a, s2_d.num_b} = prod;
      s2_d.sgn             = s1_q.sgn;
      s2_d.tag             = s1_q.tag;
      s2_d.idx             = s1_q.idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_q     <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      s2_q     <= s2_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  always_comb begin
    o_rsp_vld = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_rsp_vld[k] = s2_vld_q && (s2_q.idx == 3'(k));
    end
  end

  assign o_rsp_res = {s2_q.num_a, s2_q.num_b};
  assign o_rsp_tag = s2_q.tag[TAG_W-1:0];
  assign o_busy    = s1_vld_q | s2_vld_q;
  assign unused_s2 = ^{s2_q.sgn, s2_q.tag};

endmodule
